// File: rtl/mux_share_arbiter.sv
// Round-robin owner of a shared 2:1 mux bank with a registered, handshaked output stage.
// Each grant is limited to MAX_BURST back-to-back transfers while the other side waits.
module mux_share_arbiter #(
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] f,
    output logic             f_valid,
    input  logic             f_ready,
    output logic             busy
);

    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             f_valid_q, f_valid_d;
    logic [CW-1:0]    count_q, count_d;
    logic             last_b_q, last_b_d;
    logic [CW-1:0]    count_inc;
    logic             out_ok;

    assign out_ok    = !f_valid_q || f_ready;
    assign count_inc = count_q + 1'b1;

    assign gnt_a   = (state_q == GRANT_A) && out_ok;
    assign gnt_b   = (state_q == GRANT_B) && out_ok;
    assign sel     = sel_q;
    assign f       = f_q;
    assign f_valid = f_valid_q;
    assign busy    = (state_q != IDLE);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        f_d       = f_q;
        f_valid_d = f_valid_q;
        count_d   = count_q;
        last_b_d  = last_b_q;

        // A stalled output freezes everything; otherwise the output drains unless refilled.
        if (out_ok) begin
            f_valid_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_a && (!req_b || last_b_q)) begin
                        state_d = GRANT_A;
                    end else if (req_b) begin
                        state_d = GRANT_B;
                    end
                end
                GRANT_A: begin
                    if (!req_a) begin
                        state_d = req_b ? GRANT_B : IDLE;
                    end else begin
                        f_d       = a;
                        f_valid_d = 1'b1;
                        last_b_d  = 1'b0;
                        if (count_inc == CW'(MAX_BURST)) begin
                            count_d = '0;
                            if (req_b) state_d = GRANT_B;
                        end else begin
                            count_d = count_inc;
                        end
                    end
                end
                GRANT_B: begin
                    if (!req_b) begin
                        state_d = req_a ? GRANT_A : IDLE;
                    end else begin
                        f_d       = b;
                        f_valid_d = 1'b1;
                        last_b_d  = 1'b1;
                        if (count_inc == CW'(MAX_BURST)) begin
                            count_d = '0;
                            if (req_a) state_d = GRANT_A;
                        end else begin
                            count_d = count_inc;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase

            // Any ownership change restarts the burst; sel only moves when a grant is entered.
            if (state_d != state_q) begin
                count_d = '0;
                if (state_d != IDLE) sel_d = (state_d == GRANT_B);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            f_q       <= '0;
            f_valid_q <= 1'b0;
            count_q   <= '0;
            last_b_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            f_q       <= f_d;
            f_valid_q <= f_valid_d;
            count_q   <= count_d;
            last_b_q  <= last_b_d;
        end
    end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Bench for mux_share_arbiter: directed vector table, burst/fairness sequences,
// then randomized traffic compared against a transaction-level reference model.
module tb_mux_share_arbiter;

    localparam int WIDTH     = 4;
    localparam int MAX_BURST = 4;

    logic             clk = 1'b0;
    logic             rst, req_a, req_b, f_ready;
    logic [WIDTH-1:0] a, b;
    logic             gnt_a, gnt_b, sel, f_valid, busy;
    logic [WIDTH-1:0] f;

    mux_share_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .a(a), .req_b(req_b), .b(b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel),
        .f(f), .f_valid(f_valid), .f_ready(f_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic rst, ra; logic [3:0] a; logic rb; logic [3:0] b; logic rdy; logic chk;
        logic ga, gb, sel; logic [3:0] f; logic fv, busy;
    } vec_t;
    vec_t tbl[$];

    // Reference model: who owns the mux, how many words it has moved in this grant,
    // who moved a word most recently, and the single-entry output buffer.
    int         owner;   // 0 none, 1 A, 2 B
    int         run;
    int         last;
    logic [3:0] m_f;
    logic       m_fv, m_sel;
    logic       last_ga, last_gb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic ra, input logic [3:0] da,
                              input logic rb, input logic [3:0] db, input logic rdy);
        int mine, other, prev;
        if (r) begin
            owner = 0; run = 0; last = 2; m_f = '0; m_fv = 1'b0; m_sel = 1'b0;
            return;
        end
        if (m_fv && !rdy) return;
        prev = owner;
        m_fv = 1'b0;
        if (owner == 0) begin
            if (ra && rb) owner = (last == 1) ? 2 : 1;
            else if (ra)  owner = 1;
            else if (rb)  owner = 2;
        end else begin
            mine  = (owner == 1) ? int'(ra) : int'(rb);
            other = (owner == 1) ? int'(rb) : int'(ra);
            if (mine != 0) begin
                m_f  = (owner == 1) ? da : db;
                m_fv = 1'b1;
                last = owner;
                run++;
                if (run == MAX_BURST) begin
                    run = 0;
                    if (other != 0) owner = 3 - owner;
                end
            end else begin
                owner = (other != 0) ? 3 - owner : 0;
            end
        end
        if (owner != prev) begin
            run = 0;
            if (owner != 0) m_sel = (owner == 2);
        end
    endtask

    // Drive one cycle's inputs (at negedge), optionally check against the model, then clock.
    task automatic step(input logic r, input logic ra, input logic [3:0] da,
                        input logic rb, input logic [3:0] db, input logic rdy,
                        input bit use_model);
        logic ok;
        rst = r; req_a = ra; a = da; req_b = rb; b = db; f_ready = rdy;
        #1;
        if (use_model) begin
            ok = !m_fv || rdy;
            chk("m_gnt_a",   gnt_a,   (owner == 1) && ok);
            chk("m_gnt_b",   gnt_b,   (owner == 2) && ok);
            chk("m_sel",     sel,     m_sel);
            chk("m_f",       f,       m_f);
            chk("m_f_valid", f_valid, m_fv);
            chk("m_busy",    busy,    owner != 0);
        end
        chk("gnt_exclusive", gnt_a && gnt_b, 1'b0);
        last_ga = gnt_a; last_gb = gnt_b;
        @(posedge clk);
        model_edge(r, ra, da, rb, db, rdy);
        @(negedge clk);
    endtask

    task automatic add(input logic r, input logic ra, input logic [3:0] da, input logic rb,
                       input logic [3:0] db, input logic rdy, input logic c,
                       input logic ga, input logic gb, input logic s, input logic [3:0] ef,
                       input logic efv, input logic eb);
        vec_t v;
        v.rst = r; v.ra = ra; v.a = da; v.rb = rb; v.b = db; v.rdy = rdy; v.chk = c;
        v.ga = ga; v.gb = gb; v.sel = s; v.f = ef; v.fv = efv; v.busy = eb;
        tbl.push_back(v);
    endtask

    initial begin
        logic       ra, rb;
        logic [3:0] da, db;
        owner = 0; run = 0; last = 2; m_f = '0; m_fv = 1'b0; m_sel = 1'b0;
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; a = '0; b = '0; f_ready = 1'b1;
        @(negedge clk);

        //  rst ra a     rb b     rdy chk  ga gb sel f      fv busy
        add(1, 0, 4'h0, 0, 4'h0, 1, 0,   0, 0, 0, 4'h0, 0, 0);
        add(1, 0, 4'h0, 0, 4'h0, 1, 1,   0, 0, 0, 4'h0, 0, 0);
        add(0, 1, 4'hA, 0, 4'h0, 1, 1,   0, 0, 0, 4'h0, 0, 0);
        add(0, 1, 4'hA, 0, 4'h0, 1, 1,   1, 0, 0, 4'h0, 0, 1);
        add(0, 0, 4'h0, 1, 4'hB, 1, 1,   1, 0, 0, 4'hA, 1, 1);
        add(0, 0, 4'h0, 1, 4'hB, 1, 1,   0, 1, 1, 4'hA, 0, 1);
        add(0, 0, 4'h0, 0, 4'h0, 1, 1,   0, 1, 1, 4'hB, 1, 1);
        add(0, 0, 4'h0, 0, 4'h0, 1, 1,   0, 0, 1, 4'hB, 0, 0);
        add(0, 1, 4'h1, 0, 4'h0, 1, 1,   0, 0, 1, 4'hB, 0, 0);
        add(0, 1, 4'h1, 0, 4'h0, 1, 1,   1, 0, 0, 4'hB, 0, 1);
        add(0, 1, 4'h2, 0, 4'h0, 0, 1,   0, 0, 0, 4'h1, 1, 1);
        add(0, 1, 4'h2, 0, 4'h0, 0, 1,   0, 0, 0, 4'h1, 1, 1);
        add(0, 1, 4'h2, 0, 4'h0, 0, 1,   0, 0, 0, 4'h1, 1, 1);
        add(0, 1, 4'h2, 0, 4'h0, 1, 1,   1, 0, 0, 4'h1, 1, 1);
        add(0, 1, 4'h3, 0, 4'h0, 1, 1,   1, 0, 0, 4'h2, 1, 1);
        add(0, 1, 4'h3, 0, 4'h0, 1, 1,   1, 0, 0, 4'h3, 1, 1);
        add(1, 1, 4'h3, 0, 4'h0, 1, 1,   1, 0, 0, 4'h3, 1, 1);
        add(0, 1, 4'h0, 1, 4'h0, 1, 1,   0, 0, 0, 4'h0, 0, 0);
        add(0, 1, 4'h0, 1, 4'h0, 1, 1,   1, 0, 0, 4'h0, 0, 1);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; req_a = tbl[i].ra; a = tbl[i].a;
            req_b = tbl[i].rb; b = tbl[i].b; f_ready = tbl[i].rdy;
            #1;
            if (tbl[i].chk) begin
                chk($sformatf("t%0d_gnt_a", i),   gnt_a,   tbl[i].ga);
                chk($sformatf("t%0d_gnt_b", i),   gnt_b,   tbl[i].gb);
                chk($sformatf("t%0d_sel", i),     sel,     tbl[i].sel);
                chk($sformatf("t%0d_f", i),       f,       tbl[i].f);
                chk($sformatf("t%0d_f_valid", i), f_valid, tbl[i].fv);
                chk($sformatf("t%0d_busy", i),    busy,    tbl[i].busy);
            end
            @(posedge clk);
            model_edge(tbl[i].rst, tbl[i].ra, tbl[i].a, tbl[i].rb, tbl[i].b, tbl[i].rdy);
            @(negedge clk);
        end

        // Both requesting from IDLE: A first, then alternating bursts of MAX_BURST.
        step(1, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 25; k++) begin
            step(0, 1, 4'(k), 1, 4'(k + 8), 1, 1);
            if (k > 0) begin
                chk($sformatf("burst%0d_gnt_a", k), last_ga, ((k - 1) / MAX_BURST) % 2 == 0);
                chk($sformatf("burst%0d_gnt_b", k), last_gb, ((k - 1) / MAX_BURST) % 2 == 1);
            end
        end

        // A alone for 10 transfers: the grant is never dropped at the burst boundary.
        step(1, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k <= 10; k++) begin
            step(0, 1, 4'(k), 0, 0, 1, 1);
            if (k > 0) chk($sformatf("solo%0d_gnt_a", k), last_ga, 1'b1);
        end
        step(0, 0, 0, 0, 0, 1, 1);
        chk("solo_last_f", f, 4'd10);

        // Randomized traffic with backpressure and occasional reset.
        ra = 1'b0; rb = 1'b0; da = '0; db = '0;
        for (int k = 0; k < 600; k++) begin
            if (!ra || last_ga) begin
                ra = ($urandom_range(0, 3) != 0);
                da = 4'($urandom);
            end
            if (!rb || last_gb) begin
                rb = ($urandom_range(0, 3) != 0);
                db = 4'($urandom);
            end
            step(($urandom_range(0, 79) == 0), ra, da, rb, db, ($urandom_range(0, 3) != 0), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
